// File: rtl/packet_priority_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// packet_priority_arbiter_pkg
// Shared types and helpers for the packet priority arbiter.
//   arb_state_t : arbiter FSM state encoding
//   src_width() : width of a requester index, never less than 1 bit
// -----------------------------------------------------------------------------
package packet_priority_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    function automatic int src_width(input int inputs);
        return (inputs > 1) ? $clog2(inputs) : 1;
    endfunction

endpackage

// File: rtl/packet_priority_arbiter_picker.sv
// -----------------------------------------------------------------------------
// lowest_set_picker
// Combinational lowest-set-bit finder.
//   i_req   [N-1:0]      candidate bits
//   o_found              any bit set
//   o_index [IDX_W-1:0]  index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module lowest_set_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/packet_priority_arbiter.sv
// -----------------------------------------------------------------------------
// packet_priority_arbiter
// Fixed-priority (index 0 highest) packet arbiter. A grant is held until the
// beat carrying in_last is accepted; the output goes through a 1-entry register.
// Optional starvation guard: define PRIO_ARB_STARVE_GUARD_EN to add per-requester
// wait counters that promote a requester after MAX_WAIT waiting cycles.
//
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_last [INPUTS]   per-requester handshake and end-of-packet
//   in_data [INPUTS*WIDTH]      requester i at [i*WIDTH +: WIDTH]
//   in_ready [INPUTS]           per-requester accept (one-hot or zero)
//   out_valid/out_data/out_last registered output beat
//   out_src [SRC_W]             requester index of the current output beat
//   out_ready                   downstream accept
//
// state    | meaning
// ARB_IDLE | no grant; arbitrate among in_valid, lock the winner next cycle
// ARB_LOCK | grant fixed; forward beats from r_grant until in_last accepted
// -----------------------------------------------------------------------------
module packet_priority_arbiter
    import packet_priority_arbiter_pkg::*;
#(
    parameter int  INPUTS   = 4,
    parameter int  WIDTH    = 32,
    parameter int  MAX_WAIT = 15,
    localparam int SRC_W    = src_width(INPUTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUTS-1:0]       in_valid,
    input  logic [INPUTS*WIDTH-1:0] in_data,
    input  logic [INPUTS-1:0]       in_last,
    output logic [INPUTS-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready
);

    arb_state_t       r_state, w_state_nxt;
    logic [SRC_W-1:0] r_grant, w_grant_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [SRC_W-1:0] r_out_src;

    logic             w_norm_found;
    logic [SRC_W-1:0] w_norm_idx;
    logic [SRC_W-1:0] w_win_idx;
    logic             w_take;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_accept;

    lowest_set_picker #(.N(INPUTS), .IDX_W(SRC_W)) u_norm_pick (
        .i_req   (in_valid),
        .o_found (w_norm_found),
        .o_index (w_norm_idx)
    );

`ifdef PRIO_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait [INPUTS];
    logic [INPUTS-1:0] w_sat;
    logic              w_sat_found;
    logic [SRC_W-1:0]  w_sat_idx;

    // A saturated counter only promotes a requester that is still asking;
    // otherwise the lock would sit on an idle source.
    always_comb begin
        w_sat = '0;
        for (int i = 0; i < INPUTS; i++) begin
            w_sat[i] = in_valid[i] && (r_wait[i] == WAIT_W'(MAX_WAIT));
        end
    end

    lowest_set_picker #(.N(INPUTS), .IDX_W(SRC_W)) u_sat_pick (
        .i_req   (w_sat),
        .o_found (w_sat_found),
        .o_index (w_sat_idx)
    );

    assign w_win_idx = w_sat_found ? w_sat_idx : w_norm_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INPUTS; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < INPUTS; i++) begin
                if (r_state == ARB_IDLE && w_norm_found && w_win_idx == SRC_W'(i)) begin
                    r_wait[i] <= '0;
                end else if (in_valid[i] && !(r_state == ARB_LOCK && r_grant == SRC_W'(i))
                             && r_wait[i] != WAIT_W'(MAX_WAIT)) begin
                    r_wait[i] <= r_wait[i] + WAIT_W'(1);
                end
            end
        end
    end
`else
    logic w_unused_max_wait;
    assign w_unused_max_wait = (MAX_WAIT > 0);
    assign w_win_idx         = w_norm_idx;
`endif

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (r_grant == SRC_W'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign w_take   = !r_out_valid || out_ready;
    assign w_accept = (r_state == ARB_LOCK) && w_sel_valid && w_take;

    always_comb begin
        in_ready = '0;
        if (r_state == ARB_LOCK) begin
            for (int i = 0; i < INPUTS; i++) begin
                if (r_grant == SRC_W'(i)) in_ready[i] = w_take;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ARB_IDLE: begin
                if (w_norm_found) begin
                    w_state_nxt = ARB_LOCK;
                    w_grant_nxt = w_win_idx;
                end
            end
            ARB_LOCK: begin
                if (w_accept && w_sel_last) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_src   <= r_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_packet_priority_arbiter.sv
module tb_packet_priority_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_last = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            out_ready = 1'b1;

    packet_priority_arbiter #(.INPUTS(N), .WIDTH(W), .MAX_WAIT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } rec_t;

    rec_t        r_log[$];
    logic [32:0] r_q [N][$];
    logic [N-1:0] r_pend = '0;
    int          r_cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    // Requester models and output monitor, all evaluated away from the rising edge.
    always @(negedge clk) begin
        rec_t rec;
        if (out_valid && out_ready) begin
            rec.src  = int'(out_src);
            rec.data = out_data;
            rec.last = out_last;
            rec.cyc  = r_cyc;
            r_log.push_back(rec);
        end
        for (int i = 0; i < N; i++) begin
            if (r_pend[i] && r_q[i].size() > 0) void'(r_q[i].pop_front());
            if (r_q[i].size() > 0) begin
                in_valid[i]          = 1'b1;
                in_data[i*W +: W]    = r_q[i][0][31:0];
                in_last[i]           = r_q[i][0][32];
            end else begin
                in_valid[i] = 1'b0;
                in_last[i]  = 1'b0;
            end
            r_pend[i] = in_valid[i] & in_ready[i];
        end
    end

    function automatic logic [31:0] mk(input int src, input int pkt, input int beat);
        return {8'(src), 8'(pkt), 16'(beat)};
    endfunction

    task automatic push_pkt(input int src, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) r_q[src].push_back({(b == nbeats - 1), mk(src, pkt, b)});
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) r_q[i].delete();
        r_pend = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        flush();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r_log.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int k = 0; k < budget && r_log.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        push_pkt(0, 1, 3);
        wait_beats(1, 20);
        @(posedge clk); #3;
        rst_n = 1'b0;
        flush();
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last got=%0b exp=0", out_last); end
        vectors++; if (out_src !== '0) begin miscompares++; $display("FAIL rst_out_src got=%0d exp=0", out_src); end
        vectors++; if (in_ready !== '0) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        @(posedge clk); #1;
        r_log.delete();
        push_pkt(1, 2, 3);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL rel_idle_in_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL rel_lock_in_ready got=%b exp=0010", in_ready); end
        wait_beats(3, 30);
        vectors++;
        if (r_log.size() != 3) begin
            miscompares++; $display("FAIL rel_beats got=%0d exp=3", r_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (r_log[k].src != 1 || r_log[k].data !== mk(1, 2, k) || r_log[k].last !== (k == 2)) begin
                    miscompares++;
                    $display("FAIL rel_beat%0d got src=%0d data=%h last=%0b exp src=1 data=%h last=%0b",
                             k, r_log[k].src, r_log[k].data, r_log[k].last, mk(1, 2, k), (k == 2));
                end
            end
        end
    endtask

    task automatic test_priority();
        int esrc;
        do_reset();
        push_pkt(1, 3, 3);
        push_pkt(3, 4, 3);
        wait_beats(6, 60);
        vectors++;
        if (r_log.size() < 6) begin
            miscompares++; $display("FAIL prio_beats got=%0d exp=6", r_log.size());
            return;
        end
        for (int k = 0; k < 6; k++) begin
            esrc = (k < 3) ? 1 : 3;
            vectors++;
            if (r_log[k].src != esrc || r_log[k].data !== mk(esrc, (k < 3) ? 3 : 4, k % 3)
                || r_log[k].last !== (k % 3 == 2)) begin
                miscompares++;
                $display("FAIL prio_beat%0d got src=%0d data=%h last=%0b exp src=%0d data=%h last=%0b",
                         k, r_log[k].src, r_log[k].data, r_log[k].last, esrc,
                         mk(esrc, (k < 3) ? 3 : 4, k % 3), (k % 3 == 2));
            end
        end
        vectors++; if (r_log[1].cyc - r_log[0].cyc != 1) begin miscompares++; $display("FAIL prio_stream got=%0d exp=1", r_log[1].cyc - r_log[0].cyc); end
        vectors++; if (r_log[2].cyc - r_log[1].cyc != 1) begin miscompares++; $display("FAIL prio_stream2 got=%0d exp=1", r_log[2].cyc - r_log[1].cyc); end
        vectors++; if (r_log[3].cyc - r_log[2].cyc != 2) begin miscompares++; $display("FAIL prio_bubble got=%0d exp=2", r_log[3].cyc - r_log[2].cyc); end
    endtask

    task automatic test_lock_hold();
        int esrc;
        do_reset();
        push_pkt(2, 5, 4);
        wait_beats(1, 30);
        push_pkt(0, 6, 2);
        wait_beats(6, 60);
        vectors++;
        if (r_log.size() < 6) begin
            miscompares++; $display("FAIL lock_beats got=%0d exp=6", r_log.size());
            return;
        end
        for (int k = 0; k < 6; k++) begin
            esrc = (k < 4) ? 2 : 0;
            vectors++;
            if (r_log[k].src != esrc || r_log[k].data !== mk(esrc, (k < 4) ? 5 : 6, (k < 4) ? k : k - 4)) begin
                miscompares++;
                $display("FAIL lock_beat%0d got src=%0d data=%h exp src=%0d data=%h", k, r_log[k].src,
                         r_log[k].data, esrc, mk(esrc, (k < 4) ? 5 : 6, (k < 4) ? k : k - 4));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(1, 7, 6);
        wait_beats(2, 30);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== mk(1, 7, 2) || in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_hold%0d got valid=%0b data=%h rdy=%b exp valid=1 data=%h rdy=0000",
                         c, out_valid, out_data, in_ready, mk(1, 7, 2));
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_beats(6, 40);
        repeat (4) @(posedge clk);
        vectors++;
        if (r_log.size() != 6) begin
            miscompares++; $display("FAIL bp_count got=%0d exp=6", r_log.size());
            return;
        end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (r_log[k].data !== mk(1, 7, k) || r_log[k].last !== (k == 5)) begin
                miscompares++;
                $display("FAIL bp_beat%0d got data=%h last=%0b exp data=%h last=%0b",
                         k, r_log[k].data, r_log[k].last, mk(1, 7, k), (k == 5));
            end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int p = 0; p < 4; p++) push_pkt(0, 8 + p, 1);
        wait_beats(4, 40);
        vectors++;
        if (r_log.size() < 4) begin
            miscompares++; $display("FAIL sb_beats got=%0d exp=4", r_log.size());
            return;
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (r_log[k].src != 0 || r_log[k].data !== mk(0, 8 + k, 0) || r_log[k].last !== 1'b1) begin
                miscompares++;
                $display("FAIL sb_beat%0d got src=%0d data=%h last=%0b exp src=0 data=%h last=1",
                         k, r_log[k].src, r_log[k].data, r_log[k].last, mk(0, 8 + k, 0));
            end
            if (k > 0) begin
                vectors++;
                if (r_log[k].cyc - r_log[k-1].cyc != 2) begin
                    miscompares++;
                    $display("FAIL sb_gap%0d got=%0d exp=2", k, r_log[k].cyc - r_log[k-1].cyc);
                end
            end
        end
    endtask

    task automatic test_starve();
        int n3;
        do_reset();
        push_pkt(3, 20, 1);
        for (int p = 0; p < 12; p++) push_pkt(0, 30 + p, 1);
`ifdef PRIO_ARB_STARVE_GUARD_EN
        wait_beats(3, 40);
        vectors++;
        if (r_log.size() < 3) begin
            miscompares++; $display("FAIL starve_beats got=%0d exp=3", r_log.size());
            return;
        end
        vectors++; if (r_log[0].src != 0) begin miscompares++; $display("FAIL starve_b0 got src=%0d exp=0", r_log[0].src); end
        vectors++; if (r_log[1].src != 0) begin miscompares++; $display("FAIL starve_b1 got src=%0d exp=0", r_log[1].src); end
        vectors++;
        if (r_log[2].src != 3 || r_log[2].data !== mk(3, 20, 0)) begin
            miscompares++;
            $display("FAIL starve_b2 got src=%0d data=%h exp src=3 data=%h", r_log[2].src, r_log[2].data, mk(3, 20, 0));
        end
`else
        wait_beats(12, 80);
        vectors++;
        if (r_log.size() < 12) begin
            miscompares++; $display("FAIL nostarve_beats got=%0d exp=12", r_log.size());
            return;
        end
        n3 = 0;
        for (int k = 0; k < 12; k++) if (r_log[k].src == 3) n3++;
        vectors++; if (n3 != 0) begin miscompares++; $display("FAIL nostarve_req3 got=%0d exp=0", n3); end
        vectors++; if (r_log[11].data !== mk(0, 41, 0)) begin miscompares++; $display("FAIL nostarve_last got=%h exp=%h", r_log[11].data, mk(0, 41, 0)); end
`endif
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock_hold();
        test_backpressure();
        test_single_beat();
        test_starve();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
